// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// Segment encodings are active-high, bit0 = segment a.
package seg_pkg;

   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };
   localparam logic [6:0]  SEG_DASH  = 7'h40;
   localparam logic [6:0]  SEG_BLANK = 7'h00;
   // Dark cycles at the start of every digit slot to suppress ghosting.
   localparam int unsigned GUARD_CYC = 2;

endpackage

// File: rtl/seg_scan_driver_bcd7seg.sv
// Combinational BCD to 7-segment decoder; non-BCD codes show a dash.
module bcd7seg
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Table lookup for 0..9, dash for 10..15.
   always_comb begin
      seg = SEG_DASH;
      if (bcd <= 4'd9) seg = SEG_DIGIT[bcd];
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Tear-free multiplexed common-cathode 7-segment scan driver.
// A full frame of BCD digits is captured in one cycle at the start of slot 0;
// each slot opens with GUARD_CYC dark cycles. All outputs are registered.
// Optional macro DISP_DIM_EN adds dim_i[3:0] for PWM brightness within a slot.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned N_DIG    = 6,
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4*N_DIG-1:0] digits_i,
   input  logic               blank_lz_i,
   input  logic               colon_i,
`ifdef DISP_DIM_EN
   input  logic [3:0]         dim_i,
`endif
   output logic [6:0]         seg_o,
   output logic               dp_o,
   output logic [N_DIG-1:0]   dig_sel_o,
   output logic               frame_start_o
);

   localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned SW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

   logic [CW-1:0]      cnt, cnt_d;
   logic [SW-1:0]      slot, slot_d;
   logic [4*N_DIG-1:0] shadow, shadow_d;
   logic [6:0]         seg_d;
   logic               dp_d;
   logic [N_DIG-1:0]   sel_d;
   logic               frame_d;
   logic [3:0]         cur_dig;
   logic [6:0]         dec_seg;
   logic               active;

   assign cur_dig = shadow[{slot, 2'b00} +: 4];

   bcd7seg u_dec (
      .bcd (cur_dig),
      .seg (dec_seg)
   );

   // Prescaler/slot advance, frame capture and next-output selection.
   always_comb begin
      cnt_d    = cnt + 1'b1;
      slot_d   = slot;
      shadow_d = shadow;
      frame_d  = 1'b0;
      seg_d    = SEG_BLANK;
      dp_d     = 1'b0;
      sel_d    = '0;

      if (cnt == CW'(SCAN_DIV - 1)) begin
         cnt_d  = '0;
         slot_d = (slot == SW'(N_DIG - 1)) ? '0 : slot + 1'b1;
      end

      // Capture point; outputs are in guard here, so the old shadow is unused.
      if (cnt == '0 && slot == '0) begin
         shadow_d = digits_i;
         frame_d  = 1'b1;
      end

      active = (cnt >= CW'(GUARD_CYC));
`ifdef DISP_DIM_EN
      active = active && (4'(cnt) <= dim_i);
`endif

      if (active) begin
         sel_d[slot] = 1'b1;
         seg_d       = dec_seg;
         if (blank_lz_i && slot == '0 && cur_dig == 4'd0) seg_d = SEG_BLANK;
         dp_d = colon_i && (slot == SW'(1) || slot == SW'(3));
      end
   end

   // State and registered outputs, all cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt           <= '0;
         slot          <= '0;
         shadow        <= '0;
         seg_o         <= SEG_BLANK;
         dp_o          <= 1'b0;
         dig_sel_o     <= '0;
         frame_start_o <= 1'b0;
      end else begin
         cnt           <= cnt_d;
         slot          <= slot_d;
         shadow        <= shadow_d;
         seg_o         <= seg_d;
         dp_o          <= dp_d;
         dig_sel_o     <= sel_d;
         frame_start_o <= frame_d;
      end
   end

endmodule
